operand_fetch_stage: RTL and testbench
======================================

OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

Interface
REQ-001 Parameter DATA_W, 32, operand and register data width.
REQ-002 Parameter ADDR_W, 4, register address width (16 registers).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  decoded instruction present.
REQ-006 in_ready  out  1  stage accepts instruction this cycle.
REQ-007 in_rn, in_rm, in_rd  in  ADDR_W each  source 1, source 2, destination register.
REQ-008 in_uses_rn, in_uses_rm, in_writes_rd, in_is_load  in  1 each  decode flags.
REQ-009 rf_addr1, rf_addr2  out  ADDR_W  register-file read addresses.
REQ-010 rf_data1, rf_data2  in  DATA_W  combinational register-file read data.
REQ-011 wb_en, wb_addr, wb_data  in  1/ADDR_W/DATA_W  writeback port (mirrors register-file write port).
REQ-012 flush  in  1  kill the held output instruction.
REQ-013 out_valid  out  1; out_ready  in  1  downstream handshake.
REQ-014 out_op_a, out_op_b  out  DATA_W  captured operands.
REQ-015 out_rd  out  ADDR_W; out_writes_rd, out_is_load  out  1  forwarded decode fields.

Function
REQ-016 rf_addr1 = in_rn, rf_addr2 = in_rm, combinationally, every cycle.
REQ-017 busy[15:0] scoreboard: bit set = pending write to that register; bit 0 never set.
REQ-018 hazard = (in_uses_rn & busy[in_rn] & !byp_rn) | (in_uses_rm & busy[in_rm] & !byp_rm) | (in_writes_rd & busy[in_rd] & !byp_rd), where byp_x = wb_en & wb_addr==x (bypass terms per REQ-031/032).
REQ-019 in_ready = (!out_valid | out_ready) & !hazard & !flush.
REQ-020 Accept = in_valid & in_ready; on accept, output register loads next edge; out_valid=1 (latency 1 cycle).
REQ-021 Operand capture: out_op_a = in_uses_rn ? (byp_rn ? wb_data : rf_data1) : 0; out_op_b likewise with rm/rf_data2.
REQ-022 Register 0 source always yields rf data, never bypassed, never hazards.
REQ-023 Output fields hold stable while out_valid & !out_ready.
REQ-024 out_valid clears on out_ready & no accept in same cycle.
REQ-025 Accept with in_writes_rd & in_rd!=0 sets busy[in_rd].
REQ-026 wb_en with wb_addr!=0 clears busy[wb_addr]; simultaneous set and clear of same bit: set wins.
REQ-027 flush: out_valid cleared next edge; if flushed entry had out_writes_rd & out_rd!=0, busy[out_rd] cleared; no accept occurs in a flush cycle.
REQ-028 flush with out_valid=0: no state change other than blocking accept.
REQ-029 WAW: destination busy stalls issue until its writeback (REQ-018), guaranteeing REQ-027 clear is safe.

Reset
REQ-030 reset_n low, any time including mid-stall: out_valid=0, out_op_a=out_op_b=0, out_rd=0, out_writes_rd=0, out_is_load=0, busy=0; in_ready follows REQ-019 after release.

Configuration
REQ-031 Macro OPF_WB_BYPASS_EN defined: byp_x per REQ-018; writeback data forwarded into capture in the same cycle; zero stall cycles after writeback.
REQ-032 Macro undefined: all byp_x = 0; a busy source stalls through the writeback cycle and issues the following cycle, reading register-file data (one extra stall cycle).

Verification
REQ-033 Reset mid-stream: out_valid=1, busy[3]=1, pulse reset_n low -> out_valid=0, busy=0, outputs 0 within same cycle.
REQ-034 Back-to-back independent: R1=10,R2=20, ADD rd=4 rn=1 rm=2, out_ready=1 -> next cycle out_op_a=10, out_op_b=20, out_rd=4, busy[4]=1.
REQ-035 RAW: issue rd=4 then rn=4; in_ready=0 until wb_en,wb_addr=4,wb_data=99; with macro -> accepted that cycle, out_op_a=99; without -> accepted next cycle, out_op_a=99 from register file.
REQ-036 Backpressure: out_ready=0 two cycles -> in_ready=0, outputs unchanged; out_ready=1 -> next instruction accepted.
REQ-037 Flush: held entry rd=5 writes_rd=1, flush=1 -> out_valid=0, busy[5]=0, no accept that cycle.
REQ-038 Simultaneous: accept rd=6 while wb_en,wb_addr=6 clears older entry -> busy[6]=1 afterwards.

Source files
------------

// File: rtl/operand_fetch_stage_if.sv
// Decode-to-operand-fetch and operand-fetch-to-execute bundle.
// master drives the instruction and out_ready; slave is the fetch stage.
interface operand_fetch_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rn;
    logic [ADDR_W-1:0] in_rm;
    logic [ADDR_W-1:0] in_rd;
    logic              in_uses_rn;
    logic              in_uses_rm;
    logic              in_writes_rd;
    logic              in_is_load;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_op_a;
    logic [DATA_W-1:0] out_op_b;
    logic [ADDR_W-1:0] out_rd;
    logic              out_writes_rd;
    logic              out_is_load;

    modport master (
        output in_valid, in_rn, in_rm, in_rd,
        output in_uses_rn, in_uses_rm,
        output in_writes_rd, in_is_load,
        output out_ready,
        input  in_ready, out_valid,
        input  out_op_a, out_op_b, out_rd,
        input  out_writes_rd, out_is_load
    );

    modport slave (
        input  in_valid, in_rn, in_rm, in_rd,
        input  in_uses_rn, in_uses_rm,
        input  in_writes_rd, in_is_load,
        input  out_ready,
        output in_ready, out_valid,
        output out_op_a, out_op_b, out_rd,
        output out_writes_rd, out_is_load
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: register-file read, busy scoreboard, output register.
// Ports: clk, reset_n (async low); io (slave: in_* / out_* handshakes);
//   rf_addr1/2 out, rf_data1/2 in; wb_en/wb_addr/wb_data in; flush in.
// Optional: define OPF_WB_BYPASS_EN to forward writeback data into capture.
module operand_fetch_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    operand_fetch_stage_if.slave io,
    output logic [ADDR_W-1:0]    rf_addr1,
    output logic [ADDR_W-1:0]    rf_addr2,
    input  logic [DATA_W-1:0]    rf_data1,
    input  logic [DATA_W-1:0]    rf_data2,
    input  logic                 wb_en,
    input  logic [ADDR_W-1:0]    wb_addr,
    input  logic [DATA_W-1:0]    wb_data,
    input  logic                 flush
);
    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;
    logic              wb_hit;
    logic              byp_rn;
    logic              byp_rm;
    logic              byp_rd;
    logic              hazard;
    logic              accept;
    logic              kill_clr;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    assign rf_addr1 = io.in_rn;
    assign rf_addr2 = io.in_rm;

    // r0 is never written back, so it can neither bypass nor hazard.
    assign wb_hit = wb_en && (wb_addr != '0);

`ifdef OPF_WB_BYPASS_EN
    assign byp_rn = wb_hit && (wb_addr == io.in_rn);
    assign byp_rm = wb_hit && (wb_addr == io.in_rm);
    assign byp_rd = wb_hit && (wb_addr == io.in_rd);
`else
    assign byp_rn = 1'b0;
    assign byp_rm = 1'b0;
    assign byp_rd = 1'b0;
`endif

    assign hazard = (io.in_uses_rn   && busy[io.in_rn] && !byp_rn)
                 || (io.in_uses_rm   && busy[io.in_rm] && !byp_rm)
                 || (io.in_writes_rd && busy[io.in_rd] && !byp_rd);

    assign io.in_ready = (!io.out_valid || io.out_ready)
                      && !hazard && !flush;

    assign accept = io.in_valid && io.in_ready;

    always_comb begin
        op_a = '0;
        op_b = '0;
        if (io.in_uses_rn) op_a = byp_rn ? wb_data : rf_data1;
        if (io.in_uses_rm) op_b = byp_rm ? wb_data : rf_data2;
    end

    // A killed entry never writes back, so its reservation must be dropped.
    assign kill_clr = flush && io.out_valid && io.out_writes_rd
                   && (io.out_rd != '0);

    // Clears first, then the new reservation: a same-cycle set wins.
    always_comb begin
        busy_nxt = busy;
        if (wb_hit)   busy_nxt[wb_addr] = 1'b0;
        if (kill_clr) busy_nxt[io.out_rd] = 1'b0;
        if (accept && io.in_writes_rd && (io.in_rd != '0))
            busy_nxt[io.in_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            io.out_valid     <= 1'b0;
            io.out_op_a      <= '0;
            io.out_op_b      <= '0;
            io.out_rd        <= '0;
            io.out_writes_rd <= 1'b0;
            io.out_is_load   <= 1'b0;
        end else if (flush) begin
            io.out_valid <= 1'b0;
        end else if (accept) begin
            io.out_valid     <= 1'b1;
            io.out_op_a      <= op_a;
            io.out_op_b      <= op_b;
            io.out_rd        <= io.in_rd;
            io.out_writes_rd <= io.in_writes_rd;
            io.out_is_load   <= io.in_is_load;
        end else if (io.out_ready) begin
            io.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Testbench for operand_fetch_stage.
// Works with or without OPF_WB_BYPASS_EN defined.
module tb_operand_fetch_stage;
    logic        clk;
    logic        reset_n;
    logic [3:0]  rf_addr1;
    logic [3:0]  rf_addr2;
    logic [31:0] rf_data1;
    logic [31:0] rf_data2;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;

    operand_fetch_stage_if #(.DATA_W(32), .ADDR_W(4)) io ();

    operand_fetch_stage #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .io       (io),
        .rf_addr1 (rf_addr1),
        .rf_addr2 (rf_addr2),
        .rf_data1 (rf_data1),
        .rf_data2 (rf_data2),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .flush    (flush)
    );

`ifdef OPF_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    typedef struct {
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [3:0]  rd;
        logic        urn;
        logic        urm;
        logic        wrd;
        logic        ld;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    vec_t  sb[$];
    vec_t  vecs[6];
    int    n_err;
    int    n_chk;

    // Register file model: r0 reads a fixed nonzero value.
    logic [31:0] rf_mem [16];
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++)
                rf_mem[i] <= (i == 0) ? 32'd7 : 32'(i * 10);
        end else if (wb_en && wb_addr != 4'd0) begin
            rf_mem[wb_addr] <= wb_data;
        end
    end
    assign rf_data1 = rf_mem[rf_addr1];
    assign rf_data2 = rf_mem[rf_addr2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] rn, input logic [3:0] rm,
                                input logic [3:0] rd, input logic urn,
                                input logic urm, input logic wrd,
                                input logic ld, input logic [31:0] a,
                                input logic [31:0] b);
        vec_t v;
        v.rn = rn; v.rm = rm; v.rd = rd;
        v.urn = urn; v.urm = urm; v.wrd = wrd; v.ld = ld;
        v.a = a; v.b = b;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        io.in_valid     = 1'b1;
        io.in_rn        = v.rn;
        io.in_rm        = v.rm;
        io.in_rd        = v.rd;
        io.in_uses_rn   = v.urn;
        io.in_uses_rm   = v.urm;
        io.in_writes_rd = v.wrd;
        io.in_is_load   = v.ld;
    endtask

    // Output side: pop on completed handshake, discard on flush.
    always @(negedge clk) begin
        if (reset_n && io.out_valid) begin
            if (flush || io.out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    vec_t e;
                    e = sb.pop_front();
                    if (!flush) begin
                        chk("out_op_a", io.out_op_a, e.a);
                        chk("out_op_b", io.out_op_b, e.b);
                        chk("out_rd", io.out_rd, e.rd);
                        chk("out_wrd", io.out_writes_rd, e.wrd);
                        chk("out_ld", io.out_is_load, e.ld);
                    end
                end
            end
        end
    end

    initial begin
        vec_t v;
        n_err = 0;
        n_chk = 0;
        vecs[0] = mk(1, 2, 4, 1, 1, 0, 0, 10, 20);
        vecs[1] = mk(3, 5, 7, 1, 0, 0, 1, 30, 0);
        vecs[2] = mk(0, 9, 1, 1, 1, 0, 0, 7, 90);
        vecs[3] = mk(15, 14, 2, 0, 1, 0, 1, 0, 140);
        vecs[4] = mk(6, 0, 3, 1, 1, 0, 0, 60, 7);
        vecs[5] = mk(8, 11, 9, 0, 0, 0, 0, 0, 0);

        reset_n = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0;
        io.out_ready = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        io.in_valid = 1'b0;
        repeat (3) tick();

        chk("rst_out_valid", io.out_valid, 0);
        chk("rst_op_a", io.out_op_a, 0);
        chk("rst_op_b", io.out_op_b, 0);
        chk("rst_busy", dut.busy, 0);
        reset_n = 1'b1;
        #1;
        chk("rel_in_ready", io.in_ready, 1);
        tick();

        // Back-to-back independent instructions.
        io.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i]);
            #1;
            chk("tbl_rf_addr1", rf_addr1, vecs[i].rn);
            chk("tbl_in_ready", io.in_ready, 1);
            sb.push_back(vecs[i]);
            tick();
        end
        io.in_valid = 1'b0;
        repeat (2) tick();

        // ADD r4 = r1 + r2 reserves r4.
        v = mk(1, 2, 4, 1, 1, 1, 0, 10, 20);
        drive(v);
        sb.push_back(v);
        tick();
        chk("add_busy4", dut.busy[4], 1);

        // RAW on r4 stalls until its writeback.
        v = mk(4, 0, 0, 1, 0, 0, 0, 99, 0);
        drive(v);
        #1;
        chk("raw_stall0", io.in_ready, 0);
        tick();
        chk("raw_stall1", io.in_ready, 0);
        wb_en = 1'b1; wb_addr = 4'd4; wb_data = 32'd99;
        #1;
        chk("raw_wb_ready", io.in_ready, BYP);
`ifdef OPF_WB_BYPASS_EN
        sb.push_back(v);
        tick();
        wb_en = 1'b0;
`else
        tick();
        wb_en = 1'b0;
        #1;
        chk("raw_post_ready", io.in_ready, 1);
        sb.push_back(v);
        tick();
`endif
        io.in_valid = 1'b0;
        chk("raw_busy4", dut.busy[4], 0);
        repeat (2) tick();

        // Backpressure holds the output register.
        io.out_ready = 1'b0;
        v = mk(1, 2, 8, 1, 1, 0, 1, 10, 20);
        drive(v);
        #1;
        chk("bp_first_ready", io.in_ready, 1);
        sb.push_back(v);
        tick();
        v = mk(3, 5, 9, 1, 1, 0, 0, 30, 50);
        drive(v);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("bp_in_ready", io.in_ready, 0);
            chk("bp_valid", io.out_valid, 1);
            chk("bp_hold_a", io.out_op_a, 10);
            chk("bp_hold_rd", io.out_rd, 8);
            tick();
        end
        io.out_ready = 1'b1;
        #1;
        chk("bp_release", io.in_ready, 1);
        sb.push_back(v);
        tick();
        io.in_valid = 1'b0;
        repeat (2) tick();

        // Flush kills a held writer and releases its reservation.
        io.out_ready = 1'b0;
        v = mk(7, 0, 5, 1, 0, 1, 0, 70, 0);
        drive(v);
        sb.push_back(v);
        tick();
        chk("fl_busy5_set", dut.busy[5], 1);
        drive(mk(1, 0, 10, 1, 0, 1, 0, 10, 0));
        flush = 1'b1;
        #1;
        chk("fl_in_ready", io.in_ready, 0);
        tick();
        flush = 1'b0;
        io.in_valid = 1'b0;
        chk("fl_valid", io.out_valid, 0);
        chk("fl_busy", dut.busy, 0);
        tick();

        // New reservation beats a same-cycle writeback of the old one.
        io.out_ready = 1'b1;
        v = mk(0, 0, 6, 0, 0, 1, 0, 0, 0);
        drive(v);
        sb.push_back(v);
        tick();
        chk("sim_busy6_a", dut.busy[6], 1);
        v = mk(1, 0, 6, 1, 0, 1, 1, 10, 0);
        drive(v);
        wb_en = 1'b1; wb_addr = 4'd6; wb_data = 32'd66;
        #1;
        chk("sim_ready", io.in_ready, BYP);
`ifdef OPF_WB_BYPASS_EN
        sb.push_back(v);
        tick();
        wb_en = 1'b0;
`else
        tick();
        wb_en = 1'b0;
        #1;
        chk("sim_post_ready", io.in_ready, 1);
        sb.push_back(v);
        tick();
`endif
        io.in_valid = 1'b0;
        chk("sim_busy6_b", dut.busy[6], 1);
        wb_en = 1'b1;
        tick();
        wb_en = 1'b0;
        chk("sim_busy_clr", dut.busy, 0);
        tick();

        // Asynchronous reset in the middle of a held entry.
        io.out_ready = 1'b0;
        v = mk(2, 1, 3, 1, 1, 1, 1, 20, 10);
        drive(v);
        sb.push_back(v);
        tick();
        chk("mid_valid", io.out_valid, 1);
        chk("mid_busy3", dut.busy[3], 1);
        io.in_valid = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", io.out_valid, 0);
        chk("mid_rst_a", io.out_op_a, 0);
        chk("mid_rst_b", io.out_op_b, 0);
        chk("mid_rst_rd", io.out_rd, 0);
        chk("mid_rst_wrd", io.out_writes_rd, 0);
        chk("mid_rst_ld", io.out_is_load, 0);
        chk("mid_rst_busy", dut.busy, 0);
        sb.delete();
        reset_n = 1'b1;
        #1;
        chk("mid_rel_ready", io.in_ready, 1);
        repeat (2) tick();

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
